// File: rtl/inst_fetch_pkg.sv
// Shared fetch/decode types: packets crossing the IF/DEC boundary, fetch FSM
// states and the canonical NOP encoding.
package inst_fetch_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [29:0] pc;
        logic        pcValid;
    } dec2ifPkt;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] inst32;
        logic        instValid;
    } if2decPkt;

endpackage

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch unit with a one-entry stall hold buffer
// and flush-with-drop handling of an in-flight memory response.
//
// state | meaning
// IDLE  | no request outstanding, waiting for a valid PC
// REQ   | request on imem, address held stable until ack
// HOLD  | response captured while decode is stalled
import inst_fetch_pkg::*;

module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush_i,
    input  dec2ifPkt    dec2if_i,
    output if2decPkt    if2dec_o,
    output logic        imem_req_o,
    output logic [29:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i
);

    fetch_state_t state;
    logic         drop_q;
    logic         pend_valid_q;
    logic [29:0]  pend_pc_q;
    logic         buf_valid_q;
    logic [29:0]  buf_pc_q;
    logic [31:0]  buf_inst_q;
    logic         xfer;

    assign xfer = imem_req_o && imem_ack_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            imem_req_o   <= 1'b0;
            imem_addr_o  <= '0;
            drop_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            buf_valid_q  <= 1'b0;
            buf_pc_q     <= '0;
            buf_inst_q   <= '0;
            if2dec_o     <= '{pc: '0, inst32: NOP, instValid: 1'b0};
        end else begin
            // Bubble by default; a delivery below overrides it.
            if (flush_i || !stall) begin
                if2dec_o.inst32    <= NOP;
                if2dec_o.instValid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (dec2if_i.pcValid) begin
                        imem_addr_o <= dec2if_i.pc;
                        imem_req_o  <= 1'b1;
                        state       <= REQ;
                    end
                end

                REQ: begin
                    if (xfer) begin
                        if (flush_i || drop_q) begin
                            drop_q       <= 1'b0;
                            pend_valid_q <= 1'b0;
                            // A fresh flush supersedes any PC remembered from an earlier one.
                            if (dec2if_i.pcValid && (flush_i || !pend_valid_q)) begin
                                imem_addr_o <= dec2if_i.pc;
                            end else if (pend_valid_q && !flush_i) begin
                                imem_addr_o <= pend_pc_q;
                            end else begin
                                imem_req_o <= 1'b0;
                                state      <= IDLE;
                            end
                        end else if (stall) begin
                            buf_valid_q <= 1'b1;
                            buf_pc_q    <= imem_addr_o;
                            buf_inst_q  <= imem_rdata_i;
                            imem_req_o  <= 1'b0;
                            state       <= HOLD;
                        end else begin
                            if2dec_o <= '{pc: imem_addr_o, inst32: imem_rdata_i, instValid: 1'b1};
                            if (dec2if_i.pcValid) begin
                                imem_addr_o <= dec2if_i.pc;
                            end else begin
                                imem_req_o <= 1'b0;
                                state      <= IDLE;
                            end
                        end
                    end else if (flush_i) begin
                        drop_q       <= 1'b1;
                        pend_valid_q <= dec2if_i.pcValid;
                        pend_pc_q    <= dec2if_i.pc;
                    end
                end

                HOLD: begin
                    if (flush_i || !stall) begin
                        buf_valid_q <= 1'b0;
                        if (!flush_i) begin
                            if2dec_o <= '{pc: buf_pc_q, inst32: buf_inst_q, instValid: 1'b1};
                        end
                        if (dec2if_i.pcValid) begin
                            imem_addr_o <= dec2if_i.pc;
                            imem_req_o  <= 1'b1;
                            state       <= REQ;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    imem_req_o <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
